// File: rtl/multi_edge_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : multi_edge_pulse
//  Brief    : N-channel synchroniser, debouncer and edge-to-pulse generator
//             with optional auto-repeat while a channel is held high.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_edge_pulse #(
    parameter int N          = 4,
    parameter int DEBOUNCE   = 16,
    parameter int MODE       = 0,
    parameter int REPEAT_EN  = 0,
    parameter int REP_DELAY  = 1000,
    parameter int REP_PERIOD = 250
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_trig,
    output logic [N-1:0] out_pulse,
    output logic [N-1:0] level,
    output logic         any_pulse
);

    // Debounce counter only ever reaches DEBOUNCE-1, so it cannot wrap
    localparam int c_CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE - 1);

    // Repeat counter must hold the larger of the two reload values
    localparam int c_RC_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int c_RC_W   = $clog2(c_RC_MAX + 1);

    localparam logic c_USE_RISE = (MODE == 0) || (MODE == 2);
    localparam logic c_USE_FALL = (MODE == 1) || (MODE == 2);
    // Auto-repeat is meaningless for falling-edge-only operation
    localparam bit   c_REP_ON   = (REPEAT_EN != 0) && (MODE != 1);

    logic [N-1:0] w_pulse_d;
    logic         r_any;

    generate
        for (genvar i = 0; i < N; i++) begin : g_ch
            logic               r_s1;
            logic               r_s2;
            logic               r_level;
            logic               r_lvl_d;
            logic               r_pulse;
            logic [c_CNT_W-1:0] r_cnt;
            logic               w_rise;
            logic               w_fall;
            logic               w_rep_fire;

            // Two-flop synchroniser followed by a stable-level debouncer
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_level <= 1'b0;
                    r_lvl_d <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_s1    <= in_trig[i];
                    r_s2    <= r_s1;
                    r_lvl_d <= r_level;
                    if (r_s2 == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_level <= r_s2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_rise = r_level & ~r_lvl_d;
            assign w_fall = ~r_level & r_lvl_d;

            // Edge and repeat events are mutually exclusive: a repeat needs the
            // level high for the previous cycle, a rise needs it low
            assign w_pulse_d[i] = (c_USE_RISE & w_rise) | (c_USE_FALL & w_fall) | w_rep_fire;

            // Registered one-cycle output pulse
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pulse <= 1'b0;
                end else begin
                    r_pulse <= w_pulse_d[i];
                end
            end

            assign out_pulse[i] = r_pulse;
            assign level[i]     = r_level;

            if (c_REP_ON) begin : g_rep
                localparam logic [1:0] c_IDLE = 2'd0;
                localparam logic [1:0] c_WAIT = 2'd1;
                localparam logic [1:0] c_RPT  = 2'd2;

                logic [1:0]        r_state;
                logic [1:0]        w_state_nxt;
                logic [c_RC_W-1:0] r_rc;
                logic [c_RC_W-1:0] w_rc_nxt;

                // Repeat state and countdown register
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_state <= c_IDLE;
                        r_rc    <= '0;
                    end else begin
                        r_state <= w_state_nxt;
                        r_rc    <= w_rc_nxt;
                    end
                end

                // Next-state: a low level always drops back to idle immediately
                always_comb begin
                    w_state_nxt = r_state;
                    w_rc_nxt    = r_rc;
                    if (!r_level) begin
                        w_state_nxt = c_IDLE;
                        w_rc_nxt    = '0;
                    end else begin
                        case (r_state)
                            c_IDLE: begin
                                if (w_rise) begin
                                    w_state_nxt = c_WAIT;
                                    w_rc_nxt    = c_RC_W'(REP_DELAY);
                                end
                            end
                            c_WAIT: begin
                                if (r_rc == c_RC_W'(1)) begin
                                    w_state_nxt = c_RPT;
                                    w_rc_nxt    = c_RC_W'(REP_PERIOD);
                                end else begin
                                    w_rc_nxt = r_rc - c_RC_W'(1);
                                end
                            end
                            c_RPT: begin
                                if (r_rc == c_RC_W'(1)) begin
                                    w_rc_nxt = c_RC_W'(REP_PERIOD);
                                end else begin
                                    w_rc_nxt = r_rc - c_RC_W'(1);
                                end
                            end
                            default: begin
                                w_state_nxt = c_IDLE;
                                w_rc_nxt    = '0;
                            end
                        endcase
                    end
                end

                // Output: fire when the countdown expires while still held
                always_comb begin
                    w_rep_fire = 1'b0;
                    if (r_level && (r_state != c_IDLE) && (r_rc == c_RC_W'(1))) begin
                        w_rep_fire = 1'b1;
                    end
                end
            end else begin : g_norep
                assign w_rep_fire = 1'b0;
            end
        end
    endgenerate

    // Aggregate pulse, registered so it aligns with out_pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_pulse_d;
        end
    end

    assign any_pulse = r_any;

endmodule
`default_nettype wire

// File: tb/tb_multi_edge_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_edge_pulse
//  Brief    : Directed self-checking bench for multi_edge_pulse in rising,
//             falling, both-edge and auto-repeat configurations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_edge_pulse;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_trig;

    logic [3:0] op_m0, lv_m0, op_m1, lv_m1, op_m2, lv_m2, op_rp, lv_rp;
    logic       ap_m0, ap_m1, ap_m2, ap_rp;

    always #5 clk = ~clk;

    multi_edge_pulse #(.N(4), .DEBOUNCE(4), .MODE(0), .REPEAT_EN(0), .REP_DELAY(10), .REP_PERIOD(3))
        u_m0 (.clk(clk), .rst(rst), .in_trig(in_trig), .out_pulse(op_m0), .level(lv_m0), .any_pulse(ap_m0));
    multi_edge_pulse #(.N(4), .DEBOUNCE(4), .MODE(1), .REPEAT_EN(0), .REP_DELAY(10), .REP_PERIOD(3))
        u_m1 (.clk(clk), .rst(rst), .in_trig(in_trig), .out_pulse(op_m1), .level(lv_m1), .any_pulse(ap_m1));
    multi_edge_pulse #(.N(4), .DEBOUNCE(4), .MODE(2), .REPEAT_EN(0), .REP_DELAY(10), .REP_PERIOD(3))
        u_m2 (.clk(clk), .rst(rst), .in_trig(in_trig), .out_pulse(op_m2), .level(lv_m2), .any_pulse(ap_m2));
    multi_edge_pulse #(.N(4), .DEBOUNCE(4), .MODE(0), .REPEAT_EN(1), .REP_DELAY(10), .REP_PERIOD(3))
        u_rp (.clk(clk), .rst(rst), .in_trig(in_trig), .out_pulse(op_rp), .level(lv_rp), .any_pulse(ap_rp));

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         pc_m0[4];
    int         pc_m1[4];
    int         pc_m2[4];
    int         pc_rp[4];
    logic [3:0] lv_seen_m0;
    int         rp3_times[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < 4; c++) begin
            pc_m0[c] += int'(op_m0[c]);
            pc_m1[c] += int'(op_m1[c]);
            pc_m2[c] += int'(op_m2[c]);
            pc_rp[c] += int'(op_rp[c]);
        end
        lv_seen_m0 = lv_seen_m0 | lv_m0;
        if (op_rp[3]) rp3_times.push_back(cyc);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clr();
        for (int c = 0; c < 4; c++) begin
            pc_m0[c] = 0;
            pc_m1[c] = 0;
            pc_m2[c] = 0;
            pc_rp[c] = 0;
        end
        lv_seen_m0 = '0;
        rp3_times.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int exp4[11];
        int hi_left;
        int lo_left;
        logic [3:0] exp6;

        exp4 = '{7, 17, 20, 23, 26, 29, 32, 35, 38, 41, 44};
        rst     = 1'b1;
        in_trig = 4'b0000;
        clr();
        ticks(3);
        chk("rst_pulse", 32'(op_m0), 32'h0);
        chk("rst_level", 32'(lv_m0), 32'h0);
        chk("rst_any",   32'(ap_m0), 32'h0);
        chk("rst_rep",   32'(op_rp), 32'h0);
        rst = 1'b0;
        ticks(2);

        // Rising-edge latency on channel 0
        clr();
        in_trig = 4'b0001;
        ticks(5);
        chk("t1_lvl_e5", 32'(lv_m0), 32'h0);
        tick();
        chk("t1_lvl_e6",   32'(lv_m0), 32'h1);
        chk("t1_pulse_e6", 32'(op_m0), 32'h0);
        tick();
        chk("t1_pulse_e7", 32'(op_m0), 32'h1);
        chk("t1_any_e7",   32'(ap_m0), 32'h1);
        chk("t1_fall_e7",  32'(op_m1), 32'h0);
        tick();
        chk("t1_pulse_e8", 32'(op_m0), 32'h0);
        chk("t1_any_e8",   32'(ap_m0), 32'h0);
        ticks(10);
        chk("t1_count_hold", 32'(pc_m0[0]), 32'd1);
        in_trig = 4'b0000;
        ticks(15);
        chk("t1_count_m0", 32'(pc_m0[0]), 32'd1);
        chk("t1_count_m1", 32'(pc_m1[0]), 32'd1);
        chk("t1_count_m2", 32'(pc_m2[0]), 32'd2);

        // Short glitch rejected, long hold accepted once
        clr();
        in_trig = 4'b0010;
        ticks(3);
        in_trig = 4'b0000;
        ticks(12);
        chk("t2_glitch_lvl",   32'(lv_seen_m0), 32'h0);
        chk("t2_glitch_pulse", 32'(pc_m0[1]), 32'd0);
        in_trig = 4'b0010;
        ticks(10);
        in_trig = 4'b0000;
        ticks(15);
        chk("t2_hold_m0",  32'(pc_m0[1]), 32'd1);
        chk("t2_hold_rep", 32'(pc_rp[1]), 32'd1);
        chk("t2_lvl_end",  32'(lv_m0), 32'h0);

        // Falling-only and both-edge modes on channel 2
        clr();
        in_trig = 4'b0100;
        ticks(10);
        chk("t3_m1_press", 32'(pc_m1[2]), 32'd0);
        chk("t3_m2_press", 32'(pc_m2[2]), 32'd1);
        in_trig = 4'b0000;
        ticks(15);
        chk("t3_m1_rel", 32'(pc_m1[2]), 32'd1);
        chk("t3_m2_rel", 32'(pc_m2[2]), 32'd2);

        // Auto-repeat timing on channel 3
        clr();
        base    = cyc;
        in_trig = 4'b1000;
        ticks(40);
        in_trig = 4'b0000;
        ticks(20);
        chk("t4_rep_count", 32'(rp3_times.size()), 32'd11);
        for (int k = 0; k < 11; k++) begin
            if (k < rp3_times.size())
                chk($sformatf("t4_rep_time%0d", k), 32'(rp3_times[k] - base), 32'(exp4[k]));
        end
        chk("t4_lvl_end", 32'(lv_rp), 32'h0);

        // Reset in the middle of auto-repeat with all inputs held
        clr();
        in_trig = 4'b1111;
        ticks(20);
        rst = 1'b1;
        tick();
        chk("t5_rst1_pulse", 32'(op_rp), 32'h0);
        chk("t5_rst1_level", 32'(lv_rp), 32'h0);
        chk("t5_rst1_any",   32'(ap_rp), 32'h0);
        tick();
        chk("t5_rst2_pulse", 32'(op_rp), 32'h0);
        chk("t5_rst2_any",   32'(ap_m0), 32'h0);
        rst = 1'b0;
        clr();
        ticks(6);
        chk("t5_e6_pulse", 32'(op_rp), 32'h0);
        chk("t5_e6_level", 32'(lv_rp), 32'hf);
        tick();
        chk("t5_e7_pulse_rp", 32'(op_rp), 32'hf);
        chk("t5_e7_any_rp",   32'(ap_rp), 32'h1);
        chk("t5_e7_pulse_m0", 32'(op_m0), 32'hf);
        ticks(9);
        chk("t5_e16_pulse", 32'(op_rp), 32'h0);
        chk("t5_e16_count", 32'(pc_rp[3]), 32'd1);
        tick();
        chk("t5_e17_pulse", 32'(op_rp), 32'hf);
        in_trig = 4'b0000;
        ticks(15);

        // Glitch train on channel 0 while channel 1 is pressed and held
        clr();
        hi_left = int'($urandom_range(1, 3));
        lo_left = 0;
        for (int r = 1; r <= 60; r++) begin
            in_trig[1] = 1'b1;
            if (hi_left > 0) begin
                in_trig[0] = 1'b1;
                hi_left--;
                if (hi_left == 0) lo_left = int'($urandom_range(1, 4));
            end else begin
                in_trig[0] = 1'b0;
                lo_left--;
                if (lo_left <= 0) hi_left = int'($urandom_range(1, 3));
            end
            tick();
            exp6 = (r == 7) ? 4'b0010 : 4'b0000;
            chk($sformatf("t6_m0_c%0d", r), 32'(op_m0), 32'(exp6));
            chk($sformatf("t6_m2_c%0d", r), 32'(op_m2), 32'(exp6));
        end
        chk("t6_ch0_lvl", 32'(lv_seen_m0[0]), 32'h0);
        chk("t6_ch1_lvl", 32'(lv_m0[1]), 32'h1);
        in_trig = 4'b0000;
        ticks(15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
